// File: rtl/ram1i1o_arb.sv
// Two-requester round-robin arbiter/sequencer in front of one single-port RAM
// (asynchronous read, synchronous write). Each granted command drives the RAM
// for exactly one cycle and is answered with a one-cycle ack pulse.
module ram1i1o_arb #(
  parameter  int SZ = 2,
  parameter  int DW = 32,
  localparam int AW = (SZ > 1) ? $clog2(SZ) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_data_i,
  output logic          m0_ack_o,
  output logic [DW-1:0] m0_data_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_data_i,
  output logic          m1_ack_o,
  output logic [DW-1:0] m1_data_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_data_o,
  input  logic [DW-1:0] ram_data_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_nxt;
  logic            own_q;    // owner of the access in flight
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            last_q;   // last requester served
  logic            any_req;
  logic            win;      // winning requester when any_req is high

  // Round-robin pick: a lone request wins; on a tie the one not served last wins.
  always_comb begin
    any_req = m0_req_i | m1_req_i;
    win     = m1_req_i & (~m0_req_i | ~last_q);
  end

  // Next-state logic for the IDLE -> ACCESS -> DONE sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Command latch, ack pulses and per-requester read-data registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      own_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= 1'b1;
      m0_ack_o  <= 1'b0;
      m1_ack_o  <= 1'b0;
      m0_data_o <= '0;
      m1_data_o <= '0;
    end else begin
      // Acks are single-cycle: cleared every edge unless set by ACCESS below.
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      if (state == IDLE && any_req) begin
        own_q   <= win;
        we_q    <= win ? m1_we_i   : m0_we_i;
        addr_q  <= win ? m1_addr_i : m0_addr_i;
        wdata_q <= win ? m1_data_i : m0_data_i;
      end
      if (state == ACCESS) begin
        last_q <= own_q;
        if (own_q) begin
          m1_ack_o <= 1'b1;
          if (!we_q) m1_data_o <= ram_data_i;
        end else begin
          m0_ack_o <= 1'b1;
          if (!we_q) m0_data_o <= ram_data_i;
        end
      end
    end
  end

  // RAM drive: write only during ACCESS, and never while reset is asserted.
  always_comb begin
    ram_we_o   = (state == ACCESS) & we_q & rst_i;
    ram_addr_o = addr_q;
    ram_data_o = wdata_q;
    busy_o     = (state != IDLE);
  end

endmodule

// File: doc/ram1i1o_arb.md
Name: ram1i1o_arb

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port `ram1i1o` instance (SZ words × DW bits).
- The RAM has an asynchronous read and a synchronous write.
- Each requester issues one read or write using a req/ack handshake. The arbiter latches the winning command, drives the RAM for exactly one cycle, and returns read data with a one-cycle ack pulse.
- Used wherever two engines share a small lookup or buffer RAM.

Parameters:
- SZ, 2, RAM depth in words; AW = clog2(SZ), minimum 1.
- DW, 32, data width in bits.

Ports:
- clk_i, in, 1, clock; all state updates on posedge.
- rst_i, in, 1, reset: synchronous, active-low.
- m0_req_i, in, 1, requester 0 request; held high until m0_ack_o.
- m0_we_i, in, 1, 1 = write, 0 = read; valid while m0_req_i is high.
- m0_addr_i, in, AW, word address.
- m0_data_i, in, DW, write data.
- m0_ack_o, out, 1, one-cycle completion pulse.
- m0_data_o, out, DW, read data; valid with m0_ack_o on reads, then held.
- m1_req_i, m1_we_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o: same as the m0 ports, for requester 1.
- ram_we_o, out, 1, to RAM we_i.
- ram_addr_o, out, AW, to RAM addr_i.
- ram_data_o, out, DW, to RAM i.
- ram_data_i, in, DW, from RAM o (combinational read).
- busy_o, out, 1, high in every state except IDLE.

Behaviour:
- FSM has three states: IDLE, ACCESS, DONE. Encoding is free.
- Registers: state, own_q (owner of the current access), we_q, addr_q, wdata_q, last_q (last owner served), m0/m1 ack and data registers.
- Reset (rst_i = 0 at a posedge):
  - state = IDLE, own_q = 0, we_q = 0, addr_q = 0, wdata_q = 0, last_q = 1 (so m0 wins the first tie).
  - m0_ack_o = m1_ack_o = 0, m0_data_o = m1_data_o = 0.
- IDLE: if neither req is high, stay in IDLE.
  - If exactly one req is high, that requester wins.
  - If both are high, the winner is the requester that is not last_q.
  - The winner's we/addr/data are latched into we_q/addr_q/wdata_q, own_q = winner, next state ACCESS.
- ACCESS:
  - ram_addr_o = addr_q and ram_data_o = wdata_q.
  - ram_we_o = we_q & rst_i, so reset asserted during ACCESS suppresses the write.
  - At the posedge: if !we_q, capture ram_data_i into the owner's data register. Set the owner's ack register to 1, last_q = own_q, next state DONE.
- DONE:
  - The owner's ack is high for exactly this cycle and is cleared at the posedge; next state IDLE.
  - The requester must drop req, or present a new command, by the cycle after ack. IDLE re-samples req, so there is no double grant.
- Outside ACCESS: ram_we_o = 0, and ram_addr_o/ram_data_o still reflect addr_q/wdata_q.
- Latency: request sampled in IDLE at edge N; RAM driven in cycle N+1; ack and data visible in cycle N+2. Throughput is one access per 3 cycles.
- Fairness: with both reqs held continuously, grants alternate 0,1,0,1. No requester waits for more than one other access.
- Requester-side timing:
  - A request arriving while the arbiter is busy waits.
  - A req dropped before ack is a protocol violation and is not checked; the latched command still completes.
- Data outputs: the non-owner's data register never changes. Write accesses do not change the owner's data register.
- Address range: addresses ≥ SZ (when SZ is not a power of two) are passed through unchecked.
- busy_o = (state != IDLE), combinational from state.
- Reset at any state: next cycle is IDLE with all acks 0. The in-flight access is abandoned: no ack, and no write if reset was in ACCESS.

Test Plan:
- Reset then idle: hold rst_i = 0 for 2 cycles, then 1, no reqs. Required: ram_we_o, both acks, busy_o and both data outputs stay 0 for 10 cycles.
- Single write then read: m0 writes 0xDEADBEEF at addr 1, then reads addr 1. Required:
  - ram_we_o = 1 for exactly one cycle with ram_addr_o = 1.
  - m0_ack_o pulses 2 cycles after each req sample.
  - m0_data_o = 0xDEADBEEF on the read ack; m1_data_o stays 0.
- Simultaneous reqs after reset: m0 and m1 both read, holding req until their own ack. Required: m0 is acked first, m1 is acked 3 cycles later; no other ack pulses occur.
- Sustained contention: both requesters issue 4 back-to-back writes. Required:
  - Grant order is 0,1,0,1,0,1,0,1.
  - Each ack is exactly one cycle wide.
  - The RAM contents afterwards match the last write from each requester.
- Reset during ACCESS: m1 writes 0x12345678 to addr 0 and rst_i = 0 in the ACCESS cycle. Required: ram_we_o = 0 in that cycle, m1_ack_o never asserts, and a later m0 read of addr 0 returns the old value (0).
- Back-to-back from one requester: m1 presents a new read in the cycle after its ack. Required: it is granted in the following IDLE, with no duplicate grant of the first request.
